// File: rtl/cla_pkg.sv
// Shared carry-lookahead definitions for the team's CLA adder and subtractor.
package cla_pkg;

    localparam int unsigned CLA_BLK = 4;

    // Flat sum-of-products lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    function automatic logic [CLA_BLK:0] cla_carries(
        input logic [CLA_BLK-1:0] g,
        input logic [CLA_BLK-1:0] p,
        input logic               cin
    );
        logic [CLA_BLK:0] c;
        logic             t;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < CLA_BLK; i++) begin
            t = cin;
            for (int unsigned k = 0; k <= i; k++) t = t & p[k];
            c[i+1] = t;
            for (int unsigned j = 0; j <= i; j++) begin
                t = g[j];
                for (int unsigned k = j + 1; k <= i; k++) t = t & p[k];
                c[i+1] = c[i+1] | t;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_sub_pipe_if.sv
// Valid/ready operand and result bus for cla_sub_pipe.
interface cla_sub_pipe_if #(parameter int unsigned WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );

endinterface

// File: rtl/cla_blk.sv
// One CLA_BLK-bit carry-lookahead group: s = x + y + cin, with group carry out.
module cla_blk
    import cla_pkg::*;
(
    input  logic [CLA_BLK-1:0] x,
    input  logic [CLA_BLK-1:0] y,
    input  logic               cin,
    output logic [CLA_BLK-1:0] s,
    output logic               cout
);

    logic [CLA_BLK-1:0] w_g;
    logic [CLA_BLK-1:0] w_p;
    logic [CLA_BLK:0]   w_c;

    assign w_g  = x & y;
    assign w_p  = x ^ y;
    assign w_c  = cla_carries(w_g, w_p, cin);
    assign s    = w_p ^ w_c[CLA_BLK-1:0];
    assign cout = w_c[CLA_BLK];

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined CLA subtractor, diff = a - b - bin as a + ~b + ~bin.
// Optional unsigned saturation on borrow: define CLA_SUB_SAT_EN.
module cla_sub_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLK   = CLA_BLK
)(
    input  logic          clk,
    input  logic          rst,
    cla_sub_pipe_if.slave bus
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned NG   = HALF / BLK;

    logic [WIDTH-1:0] w_nb;
    logic [NG:0]      w_lo_c;
    logic [HALF-1:0]  w_lo_s;
    logic [NG:0]      w_hi_c;
    logic [HALF-1:0]  w_hi_s;
    logic [WIDTH-1:0] w_diff_raw;
    logic [WIDTH-1:0] w_diff_fin;
    logic             w_bout;
    logic             w_ovf;
    logic             w_s1_adv;
    logic             w_s2_adv;

    logic             r_s1_valid;
    logic [HALF-1:0]  r_lo_diff;
    logic             r_mid_c;
    logic [HALF-1:0]  r_a_hi;
    logic [HALF-1:0]  r_nb_hi;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    assign w_nb      = ~bus.b;
    assign w_lo_c[0] = ~bus.bin;
    assign w_hi_c[0] = r_mid_c;

    for (genvar gi = 0; gi < NG; gi++) begin : g_lo
        cla_blk u_blk (
            .x    (bus.a[gi*BLK +: BLK]),
            .y    (w_nb[gi*BLK +: BLK]),
            .cin  (w_lo_c[gi]),
            .s    (w_lo_s[gi*BLK +: BLK]),
            .cout (w_lo_c[gi+1])
        );
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_hi
        cla_blk u_blk (
            .x    (r_a_hi[gi*BLK +: BLK]),
            .y    (r_nb_hi[gi*BLK +: BLK]),
            .cin  (w_hi_c[gi]),
            .s    (w_hi_s[gi*BLK +: BLK]),
            .cout (w_hi_c[gi+1])
        );
    end

    assign w_diff_raw = {w_hi_s, r_lo_diff};
    assign w_bout     = ~w_hi_c[NG];
    // b's sign bit is the complement of the registered ~b_hi sign bit.
    assign w_ovf      = (r_a_hi[HALF-1] != ~r_nb_hi[HALF-1]) &
                        (w_diff_raw[WIDTH-1] != r_a_hi[HALF-1]);

`ifdef CLA_SUB_SAT_EN
    assign w_diff_fin = w_bout ? '0 : w_diff_raw;
`else
    assign w_diff_fin = w_diff_raw;
`endif

    assign w_s2_adv     = !r_out_valid || bus.out_ready;
    assign w_s1_adv     = !r_s1_valid || w_s2_adv;
    assign bus.in_ready = w_s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_lo_diff  <= '0;
            r_mid_c    <= 1'b0;
            r_a_hi     <= '0;
            r_nb_hi    <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_lo_diff <= w_lo_s;
                r_mid_c   <= w_lo_c[NG];
                r_a_hi    <= bus.a[WIDTH-1:HALF];
                r_nb_hi   <= w_nb[WIDTH-1:HALF];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_diff <= w_diff_fin;
                r_bout <= w_bout;
                r_ovf  <= w_ovf;
                r_zero <= ~|w_diff_fin;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Self-checking bench for cla_sub_pipe (WIDTH=16) against an arithmetic reference model.
module tb_cla_sub_pipe;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_acc;
    exp_t exp_q[$];

    cla_sub_pipe_if #(.WIDTH(W)) bus ();

    cla_sub_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a_, input logic [W-1:0] b_, input logic bi);
        exp_t        r;
        logic [W:0]  u;
        int          sd;
        u      = {1'b0, a_} - {1'b0, b_} - {{W{1'b0}}, bi};
        r.diff = u[W-1:0];
        r.bout = u[W];
        sd     = int'($signed(a_)) - int'($signed(b_)) - int'(bi);
        r.ovf  = (sd > 32767) || (sd < -32768);
`ifdef CLA_SUB_SAT_EN
        if (r.bout) r.diff = '0;
`endif
        r.zero = (r.diff == '0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a_, input logic [W-1:0] b_,
                         input logic bi, input logic ordy);
        bus.in_valid  = v;
        bus.a         = a_;
        bus.b         = b_;
        bus.bin       = bi;
        bus.out_ready = ordy;
    endtask

    // One clock: check presented result against the model front, book handshakes, advance.
    task automatic step();
        exp_t e;
        #1;
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {31'b0, bus.out_valid}, 32'd0);
            end else begin
                e = exp_q[0];
                chk("diff", {16'b0, bus.diff}, {16'b0, e.diff});
                chk("bout", {31'b0, bus.bout}, {31'b0, e.bout});
                chk("ovf",  {31'b0, bus.ovf},  {31'b0, e.ovf});
                chk("zero", {31'b0, bus.zero}, {31'b0, e.zero});
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
        if (!rst && bus.in_valid && bus.in_ready === 1'b1) begin
            exp_q.push_back(model(bus.a, bus.b, bus.bin));
            n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] d, input logic bo,
                              input logic ov, input logic z);
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, "_diff"},  {16'b0, bus.diff}, {16'b0, d});
        chk({tag, "_bout"},  {31'b0, bus.bout}, {31'b0, bo});
        chk({tag, "_ovf"},   {31'b0, bus.ovf},  {31'b0, ov});
        chk({tag, "_zero"},  {31'b0, bus.zero}, {31'b0, z});
    endtask

    task automatic single(input string tag, input logic [W-1:0] a_, input logic [W-1:0] b_,
                          input logic bi, input logic [W-1:0] d, input logic bo,
                          input logic ov, input logic z);
        drive(1'b1, a_, b_, bi, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        chk({tag, "_lat1"}, {31'b0, bus.out_valid}, 32'd0);
        step();
        expect_out(tag, d, bo, ov, z);
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_acc    = 0;
        rst      = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_diff",      {16'b0, bus.diff}, 32'd0);
        chk("rst_flags",     {29'b0, bus.bout, bus.ovf, bus.zero}, 32'd0);
        chk("rst_in_ready",  {31'b0, bus.in_ready}, 32'd1);

        single("t1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
`ifdef CLA_SUB_SAT_EN
        single("t2", 16'h0000, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
`else
        single("t2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
`endif
        single("t3a", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        single("t3b", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0);
        single("t4a", 16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Back-to-back stream: results must come out on consecutive cycles.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            if (i >= 2) chk("stream_valid", {31'b0, bus.out_valid}, 32'd1);
            step();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk("stream_tail_valid", {31'b0, bus.out_valid}, 32'd1);
            step();
        end
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // Stall: out_ready low, three offers, only two fit.
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
            if (i == 2) begin
                #1;
                chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
                step();
            end else begin
                step();
            end
        end
        chk("stall_accepted", 32'(n_acc), 32'd2);
        chk("stall_in_ready_hold", {31'b0, bus.in_ready}, 32'd0);
        step();
        bus.out_ready = 1'b1;
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        chk("stall_accepted_all", 32'(n_acc), 32'd3);
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two ops in flight.
        drive(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1);
        step();
        drive(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("rst6_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst6_diff",      {16'b0, bus.diff}, 32'd0);
        chk("rst6_in_ready",  {31'b0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rst6_no_stale", {31'b0, bus.out_valid}, 32'd0);
            step();
        end

        // Random traffic with random back-pressure.
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                  ($urandom_range(3) != 0));
            step();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
